invsqrt_rr_sched: RTL

//  Round-robin scheduler that shares one fixed-latency invsqrt pipeline between NUM_REQ requesters.

---
 rtl/invsqrt_rr_sched.sv | 116 +++++++++++
 1 files changed

// File: rtl/invsqrt_rr_sched.sv
// Round-robin front end sharing one fixed-latency invsqrt pipeline.
// Requester IDs ride a tag line matched to the pipeline depth.
module invsqrt_rr_sched #(
  parameter int NUM_REQ  = 4,
  parameter int PIPE_LAT = 4,
  parameter int DW       = 31
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        pause,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DW-1:0]       req_number,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        pipe_valid,
  output logic [DW-1:0]               pipe_number,
  input  logic                        pipe_done,
  input  logic [DW-1:0]               pipe_result,
  output logic [NUM_REQ-1:0]          res_valid,
  output logic [DW-1:0]               res_data,
  output logic [$clog2(PIPE_LAT+2)-1:0] in_flight,
  output logic                        tag_err
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int FW = $clog2(PIPE_LAT + 2);
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  logic [IW-1:0] ptr;
  logic [IW-1:0] gnt_id;
  logic [IW-1:0] pipe_id;
  logic          gnt_hit;
  logic          accept;
  int            scan_idx;

  logic          tag_v  [PIPE_LAT];
  logic [IW-1:0] tag_id [PIPE_LAT];
  logic [FW-1:0] drain;

  logic [DW-1:0] req_op [NUM_REQ];

  logic          tail_v;
  logic [IW-1:0] tail_id;
  logic          chk_en;
  logic          hit;
  logic          miss;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_op
    assign req_op[i] = req_number[i*DW +: DW];
  end

  // Descending scan so the nearest valid requester to ptr wins.
  always_comb begin
    gnt_id   = '0;
    gnt_hit  = 1'b0;
    scan_idx = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      scan_idx = (int'(ptr) + k) % NUM_REQ;
      if (req_valid[scan_idx]) begin
        gnt_id  = IW'(scan_idx);
        gnt_hit = 1'b1;
      end
    end
  end

  assign req_ready = (gnt_hit && !pause && !rst)
                   ? (ONE << gnt_id) : '0;
  assign accept    = |req_ready;

  assign tail_v  = tag_v[PIPE_LAT-1];
  assign tail_id = tag_id[PIPE_LAT-1];
  assign chk_en  = (drain == '0);
  assign hit     = chk_en & tail_v & pipe_done;
  assign miss    = chk_en & (tail_v ^ pipe_done);

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr         <= '0;
      pipe_valid  <= 1'b0;
      pipe_number <= '0;
      pipe_id     <= '0;
      res_valid   <= '0;
      res_data    <= '0;
      in_flight   <= '0;
      tag_err     <= 1'b0;
      drain       <= FW'(PIPE_LAT + 1);
      for (int i = 0; i < PIPE_LAT; i++) begin
        tag_v[i]  <= 1'b0;
        tag_id[i] <= '0;
      end
    end else begin
      pipe_valid <= accept;
      if (accept) begin
        pipe_number <= req_op[gnt_id];
        pipe_id     <= gnt_id;
        ptr <= (gnt_id == IW'(NUM_REQ - 1))
             ? '0 : gnt_id + IW'(1);
      end
      tag_v[0]  <= pipe_valid;
      tag_id[0] <= pipe_id;
      for (int i = 1; i < PIPE_LAT; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
      res_valid <= hit ? (ONE << tail_id) : '0;
      if (hit) res_data <= pipe_result;
      if (miss) tag_err <= 1'b1;
      if (drain != '0) drain <= drain - FW'(1);
      unique case ({accept, tail_v})
        2'b10:   in_flight <= in_flight + FW'(1);
        2'b01:   in_flight <= in_flight - FW'(1);
        default: in_flight <= in_flight;
      endcase
    end
  end

endmodule
